// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizing for the data-memory arbiter slice.
// Build option DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority with starvation guard.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_DATA_WIDTH = 32;
  localparam int unsigned DMEM_DEPTH      = 256;
  localparam int unsigned DMEM_ADDR_WIDTH = $clog2(DMEM_DEPTH);

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_id_t;

  typedef struct packed {
    logic                       we;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [DMEM_DATA_WIDTH-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_grant.sv
// Combinational grant select for the two memory ports (module arb_grant).
// DMEM_ARB_RR_EN: round-robin on contention; otherwise port 0 wins unless port 1 is starved.
module arb_grant
  import dmem_arbiter_pkg::*;
(
  input  logic lock_i,
  input  logic valid0_i,
  input  logic valid1_i,
`ifdef DMEM_ARB_RR_EN
  input  logic last_grant_i,
`else
  input  logic wait_sat_i,
`endif
  output logic gnt0_o,
  output logic gnt1_o
);

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (lock_i) begin
      gnt1_o = valid1_i;
    end else if (valid0_i && valid1_i) begin
`ifdef DMEM_ARB_RR_EN
      if (port_id_t'(last_grant_i) == PORT_CPU) gnt1_o = 1'b1;
      else                                      gnt0_o = 1'b1;
`else
      if (wait_sat_i) gnt1_o = 1'b1;
      else            gnt0_o = 1'b1;
`endif
    end else begin
      gnt0_o = valid0_i;
      gnt1_o = valid1_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (port 0) and a debug/loader port (port 1).
// Build option DMEM_ARB_RR_EN: round-robin arbitration; the starvation counter is then not built.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = DMEM_DEPTH,
  parameter int unsigned MAX_WAIT   = 8,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_req0_valid,
  input  logic                  i_req0_we,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  output logic                  o_req0_ready,
  output logic                  o_req0_rvalid,
  output logic [DATA_WIDTH-1:0] o_req0_rdata,
  input  logic                  i_req1_valid,
  input  logic                  i_req1_we,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  input  logic                  i_req1_lock,
  output logic                  o_req1_ready,
  output logic                  o_req1_rvalid,
  output logic [DATA_WIDTH-1:0] o_req1_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_cpu_stall
);

  arb_state_t            state_q, state_d;
  logic                  rd_pend_q, rd_pend_d;
  port_id_t              rd_owner_q, rd_owner_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  gnt0, gnt1;
  port_id_t              winner;

`ifdef DMEM_ARB_RR_EN
  port_id_t last_grant_q, last_grant_d;
`else
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              wait_sat;
  assign wait_sat = (wait_q == WAIT_W'(MAX_WAIT));
`endif

  arb_grant u_grant (
    .lock_i      (state_q == LOCK1),
    .valid0_i    (i_req0_valid),
    .valid1_i    (i_req1_valid),
`ifdef DMEM_ARB_RR_EN
    .last_grant_i(last_grant_q),
`else
    .wait_sat_i  (wait_sat),
`endif
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1)
  );

  // Grants are masked while reset is held so no strobe escapes during reset.
  assign o_req0_ready = gnt0 & i_reset_n;
  assign o_req1_ready = gnt1 & i_reset_n;
  assign o_cpu_stall  = i_req0_valid & ~o_req0_ready & i_reset_n;
  assign winner       = o_req1_ready ? PORT_DBG : PORT_CPU;

  always_comb begin
    o_mem_en    = o_req0_ready | o_req1_ready;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (o_req1_ready) begin
      o_mem_we    = i_req1_we;
      o_mem_addr  = i_req1_addr;
      o_mem_wdata = i_req1_wdata;
    end else if (o_req0_ready) begin
      o_mem_we    = i_req0_we;
      o_mem_addr  = i_req0_addr;
      o_mem_wdata = i_req0_wdata;
    end
  end

  assign o_req0_rvalid = rd_pend_q & (rd_owner_q == PORT_CPU);
  assign o_req1_rvalid = rd_pend_q & (rd_owner_q == PORT_DBG);
  assign o_req0_rdata  = o_req0_rvalid ? i_mem_rdata : rdata0_q;
  assign o_req1_rdata  = o_req1_rvalid ? i_mem_rdata : rdata1_q;

  always_comb begin
    state_d = state_q;
    if (o_req1_ready) state_d = i_req1_lock ? LOCK1 : ARB;
    rd_pend_d  = o_mem_en & ~o_mem_we;
    rd_owner_d = winner;
    rdata0_d   = o_req0_rdata;
    rdata1_d   = o_req1_rdata;
`ifdef DMEM_ARB_RR_EN
    last_grant_d = o_mem_en ? winner : last_grant_q;
`else
    wait_d = wait_q;
    if (o_req1_ready)                  wait_d = '0;
    else if (i_req1_valid && !wait_sat) wait_d = wait_q + 1'b1;
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ARB;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= PORT_CPU;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant_q <= PORT_DBG;
`else
      wait_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`else
      wait_q       <= wait_d;
`endif
    end
  end

endmodule
